// File: rtl/morse_pkg.sv
// Shared Morse encoding and timing constants for the transmitter and receiver paths.
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    SYM_GAP,
    CHAR_GAP,
    WORD_GAP
  } state_t;

  localparam logic [2:0] DOT_UNITS      = 3'd1;
  localparam logic [2:0] DASH_UNITS     = 3'd3;
  localparam logic [2:0] SYM_GAP_UNITS  = 3'd1;
  localparam logic [2:0] CHAR_GAP_UNITS = 3'd3;
  localparam logic [2:0] WORD_GAP_UNITS = 3'd4;

  localparam int LEN_MSB = 7;
  localparam int LEN_LSB = 5;
  localparam int SYM_MSB = 4;

  localparam logic [2:0] MAX_SYMBOLS = 3'd5;

  // Out-of-range lengths (6, 7) are treated as a full five-symbol character.
  function automatic logic [2:0] clamp_len(input logic [2:0] len);
    return (len > MAX_SYMBOLS) ? MAX_SYMBOLS : len;
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Interval timer: on load, counts units*UNIT_CYCLES cycles and flags the last one with expire.
module morse_unit_timer #(
  parameter int UNIT_CYCLES = 1500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [2:0] units,
  output logic       expire
);

  localparam int CW = $clog2(4 * UNIT_CYCLES);

  logic [CW-1:0] cnt;
  logic          running;

  // NOTE: sequential state is always written with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (load) begin
      cnt     <= CW'(int'(units) * UNIT_CYCLES - 1);
      running <= 1'b1;
    end else if (running) begin
      if (cnt == '0) running <= 1'b0;
      else           cnt     <= cnt - 1'b1;
    end
  end

  assign expire = running && (cnt == '0);

endmodule

// File: rtl/morse_output.sv
// Morse transmitter: accepts one packed character per handshake and keys dots, dashes and gaps.
module morse_output
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 1500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] morse_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       key_out,
  output logic       busy,
  output logic       done
);

  state_t     state;
  logic [4:0] shreg;
  logic [2:0] count;
  logic       accept;
  logic       load;
  logic [2:0] units;
  logic       expire;
  logic [2:0] len_raw;

  assign accept  = in_valid && in_ready;
  assign len_raw = morse_in[LEN_MSB:LEN_LSB];

  morse_unit_timer #(.UNIT_CYCLES(UNIT_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .units  (units),
    .expire (expire)
  );

  // Timer reload on every state change, with the length of the interval being entered.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    load  = 1'b0;
    units = DOT_UNITS;
    case (state)
      IDLE: if (accept) begin
        load  = 1'b1;
        units = (len_raw == 3'd0) ? WORD_GAP_UNITS
              : (morse_in[SYM_MSB] ? DASH_UNITS : DOT_UNITS);
      end
      MARK: if (expire) begin
        load  = 1'b1;
        units = (count > 3'd1) ? SYM_GAP_UNITS : CHAR_GAP_UNITS;
      end
      SYM_GAP: if (expire) begin
        load  = 1'b1;
        units = shreg[4] ? DASH_UNITS : DOT_UNITS;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      shreg    <= '0;
      count    <= '0;
      key_out  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          shreg    <= morse_in[SYM_MSB:0];
          count    <= clamp_len(len_raw);
          busy     <= 1'b1;
          in_ready <= 1'b0;
          if (len_raw == 3'd0) begin
            state   <= WORD_GAP;
            key_out <= 1'b0;
          end else begin
            state   <= MARK;
            key_out <= 1'b1;
          end
        end
        MARK: if (expire) begin
          key_out <= 1'b0;
          shreg   <= {shreg[3:0], 1'b0};
          count   <= count - 3'd1;
          state   <= (count > 3'd1) ? SYM_GAP : CHAR_GAP;
        end
        SYM_GAP: if (expire) begin
          key_out <= 1'b1;
          state   <= MARK;
        end
        CHAR_GAP, WORD_GAP: if (expire) begin
          state    <= IDLE;
          busy     <= 1'b0;
          in_ready <= 1'b1;
          done     <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          key_out  <= 1'b0;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_output.sv
// Directed bench for morse_output with a 4-cycle unit; outputs are sampled on falling edges.
module tb_morse_output;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] morse_in;
  logic       in_valid;
  logic       in_ready;
  logic       key_out;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  morse_output #(.UNIT_CYCLES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .morse_in (morse_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .key_out  (key_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Checks key_out over n consecutive cycles, leaving the bench at the following cycle.
  task automatic key_run(input string tag, input logic val, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s[%0d]", tag, i), {7'd0, key_out}, {7'd0, val});
      @(negedge clk);
    end
  endtask

  task automatic check_done_cycle(input string tag);
    check({tag, "_done"},  {7'd0, done},     8'd1);
    check({tag, "_ready"}, {7'd0, in_ready}, 8'd1);
    check({tag, "_busy"},  {7'd0, busy},     8'd0);
    check({tag, "_key"},   {7'd0, key_out},  8'd0);
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    morse_in = 8'h00;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_key",   {7'd0, key_out},  8'd0);
    check("rst_busy",  {7'd0, busy},     8'd0);
    check("rst_ready", {7'd0, in_ready}, 8'd1);
    check("rst_done",  {7'd0, done},     8'd0);

    // E: one dot then the character gap
    morse_in = 8'h20; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("e_busy",  {7'd0, busy},     8'd1);
    check("e_ready", {7'd0, in_ready}, 8'd0);
    key_run("e_on",  1'b1, 4);
    key_run("e_off", 1'b0, 12);
    check_done_cycle("e");
    @(negedge clk);
    check("e_done_pulse", {7'd0, done}, 8'd0);

    // U then I streamed with in_valid held high
    morse_in = 8'h64; in_valid = 1'b1;
    @(negedge clk);
    morse_in = 8'h40;
    key_run("u_on0",  1'b1, 4);
    key_run("u_off0", 1'b0, 4);
    key_run("u_on1",  1'b1, 4);
    key_run("u_off1", 1'b0, 4);
    key_run("u_on2",  1'b1, 12);
    key_run("u_off2", 1'b0, 12);
    check_done_cycle("u");
    @(negedge clk);
    in_valid = 1'b0;
    check("i_busy", {7'd0, busy}, 8'd1);
    key_run("i_on0",  1'b1, 4);
    key_run("i_off0", 1'b0, 4);
    key_run("i_on1",  1'b1, 4);
    key_run("i_off1", 1'b0, 12);
    check_done_cycle("i");
    @(negedge clk);

    // T followed by a word space
    morse_in = 8'h30; in_valid = 1'b1;
    @(negedge clk);
    morse_in = 8'h00;
    key_run("t_on",  1'b1, 12);
    key_run("t_off", 1'b0, 12);
    check_done_cycle("t");
    @(negedge clk);
    in_valid = 1'b0;
    check("ws_busy", {7'd0, busy}, 8'd1);
    key_run("ws_off", 1'b0, 16);
    check_done_cycle("ws");
    @(negedge clk);

    // New character offered mid-dash is ignored
    morse_in = 8'h30; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    key_run("ig_on0", 1'b1, 5);
    morse_in = 8'h20; in_valid = 1'b1;
    check("ig_ready", {7'd0, in_ready}, 8'd0);
    key_run("ig_on1", 1'b1, 7);
    in_valid = 1'b0;
    key_run("ig_off", 1'b0, 12);
    check_done_cycle("ig");
    @(negedge clk);
    check("ig_idle_key", {7'd0, key_out}, 8'd0);

    // Reset pulse during the first dash of an over-length character
    morse_in = 8'hFF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    key_run("ab_on", 1'b1, 6);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("ab_key",   {7'd0, key_out},  8'd0);
    check("ab_busy",  {7'd0, busy},     8'd0);
    check("ab_ready", {7'd0, in_ready}, 8'd1);
    @(negedge clk);
    check("ab_idle_key", {7'd0, key_out}, 8'd0);

    // Rerun 0xFF: clamped to five dashes
    morse_in = 8'hFF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int s = 0; s < 4; s++) begin
      key_run($sformatf("cl_on%0d", s),  1'b1, 12);
      key_run($sformatf("cl_off%0d", s), 1'b0, 4);
    end
    key_run("cl_on4",  1'b1, 12);
    key_run("cl_off4", 1'b0, 12);
    check_done_cycle("cl");
    @(negedge clk);
    key_run("cl_after", 1'b0, 4);
    check("cl_after_busy", {7'd0, busy}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
